ysyx_24100006_pipe_buf: RTL and testbench

Parametrised pipeline-stage buffer for the ysyx_24100006 core. It replaces the fixed single-entry inter-stage registers (IF_ID, ID_EX, EX_MEM, MEM_WB) with one generic block. The block has a configurable payload width, a configurable depth, a selectable ready mode (pass-through or registered), and a synchronous flush used on branch/trap redirect. It sits between two pipeline stages and carries one flattened payload vector per valid/ready transfer.

---
 rtl/ysyx_24100006_pipe_buf.sv | 82 ++++++++
 tb/tb_ysyx_24100006_pipe_buf.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100006_pipe_buf.sv
// Generic inter-stage buffer: DEPTH-entry circular queue with valid/ready
// handshakes, optional same-cycle slide when full, and redirect flush.
module ysyx_24100006_pipe_buf #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned DEPTH      = 1,
   parameter bit          PASS_READY = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULLC = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_rd_ptr;
   logic [PW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [PW-1:0]    w_rd_nxt;
   logic [PW-1:0]    w_wr_nxt;

   assign w_full  = (r_count == FULLC);
   assign w_empty = (r_count == '0);

   // Pass mode lets a full buffer accept while the head leaves.
   assign in_ready  = PASS_READY ? (!w_full || out_ready) : !w_full;
   assign out_valid = !w_empty;
   assign out_data  = r_mem[r_rd_ptr];
   assign count     = r_count;

   assign w_push = in_valid && in_ready && !flush;
   assign w_pop  = out_valid && out_ready && !flush;

   assign w_rd_nxt = (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PW'(1);
   assign w_wr_nxt = (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= w_wr_nxt;
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_nxt;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_24100006_pipe_buf.sv
// Directed vector bench for ysyx_24100006_pipe_buf across several
// DEPTH / PASS_READY configurations sharing one stimulus bus.
module tb_ysyx_24100006_pipe_buf;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_data;

   logic        ir0, ov0;
   logic [31:0] od0;
   logic [0:0]  c0;
   logic        ir1, ov1;
   logic [7:0]  od1;
   logic [2:0]  c1;
   logic        ir2, ov2;
   logic [7:0]  od2;
   logic [1:0]  c2;
   logic        ir3, ov3;
   logic [7:0]  od3;
   logic [1:0]  c3;
   logic        ir4, ov4;
   logic [7:0]  od4;
   logic [0:0]  c4;

   ysyx_24100006_pipe_buf u0 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
      .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
      .count(c0)
   );

   ysyx_24100006_pipe_buf #(.WIDTH(8), .DEPTH(4), .PASS_READY(1'b0)) u1 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(ir1), .in_data(in_data[7:0]),
      .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
      .count(c1)
   );

   ysyx_24100006_pipe_buf #(.WIDTH(8), .DEPTH(3), .PASS_READY(1'b1)) u2 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(ir2), .in_data(in_data[7:0]),
      .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
      .count(c2)
   );

   ysyx_24100006_pipe_buf #(.WIDTH(8), .DEPTH(2), .PASS_READY(1'b1)) u3 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(ir3), .in_data(in_data[7:0]),
      .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
      .count(c3)
   );

   ysyx_24100006_pipe_buf #(.WIDTH(8), .DEPTH(1), .PASS_READY(1'b0)) u4 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(ir4), .in_data(in_data[7:0]),
      .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
      .count(c4)
   );

   int          sel;
   logic        c_ir, c_ov;
   logic [31:0] c_od;
   logic [2:0]  c_cnt;

   always_comb begin
      c_ir  = ir0;
      c_ov  = ov0;
      c_od  = od0;
      c_cnt = {2'b00, c0};
      case (sel)
         1: begin c_ir = ir1; c_ov = ov1; c_od = {24'h0, od1}; c_cnt = c1; end
         2: begin c_ir = ir2; c_ov = ov2; c_od = {24'h0, od2}; c_cnt = {1'b0, c2}; end
         3: begin c_ir = ir3; c_ov = ov3; c_od = {24'h0, od3}; c_cnt = {1'b0, c3}; end
         4: begin c_ir = ir4; c_ov = ov4; c_od = {24'h0, od4}; c_cnt = {2'b00, c4}; end
         default: ;
      endcase
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      int          inst;
      bit          rst;
      bit          fl;
      bit          iv;
      logic [31:0] id;
      bit          ordy;
      bit          e_ir;
      bit          e_ov;
      logic [31:0] e_od;
      int          e_cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input int inst, input bit fl, input bit iv,
                               input logic [31:0] id, input bit ordy,
                               input bit e_ir, input bit e_ov,
                               input logic [31:0] e_od, input int e_cnt);
      vec_t v;
      v.inst = inst; v.rst = 1'b0; v.fl = fl; v.iv = iv; v.id = id;
      v.ordy = ordy; v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od;
      v.e_cnt = e_cnt;
      tbl.push_back(v);
   endfunction

   function automatic void add_rst(input int inst);
      vec_t v;
      v.inst = inst; v.rst = 1'b1; v.fl = 1'b0; v.iv = 1'b0; v.id = '0;
      v.ordy = 1'b0; v.e_ir = 1'b0; v.e_ov = 1'b0; v.e_od = '0; v.e_cnt = 0;
      tbl.push_back(v);
   endfunction

   bit          pat[16] = '{0,0,0,1,0,1,1,0,1,1,1,1,1,1,1,1};
   logic [7:0]  q[$];
   logic [7:0]  nxt;
   bit          exp_ir;

   initial begin
      // DEPTH=1 PASS=1: reset/idle, streaming, stall
      add_rst(0);
      for (int i = 0; i < 5; i++) add(0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0);
      add(0, 0, 1, 32'h11, 1, 1, 0, 32'h00, 0);
      add(0, 0, 1, 32'h22, 1, 1, 1, 32'h11, 1);
      add(0, 0, 1, 32'h33, 1, 1, 1, 32'h22, 1);
      add(0, 0, 0, 32'h00, 1, 1, 1, 32'h33, 1);
      add(0, 0, 0, 32'h00, 1, 1, 0, 32'h33, 0);
      add(0, 0, 1, 32'h44, 0, 1, 0, 32'h33, 0);
      add(0, 0, 1, 32'h55, 0, 0, 1, 32'h44, 1);
      add(0, 0, 0, 32'h00, 0, 0, 1, 32'h44, 1);
      add(0, 0, 0, 32'h00, 1, 1, 1, 32'h44, 1);
      add(0, 0, 0, 32'h00, 0, 1, 0, 32'h44, 0);
      // DEPTH=4 PASS=0 backpressure then drain
      add_rst(1);
      add(1, 0, 1, 32'hA0, 0, 1, 0, 32'h00, 0);
      add(1, 0, 1, 32'hA1, 0, 1, 1, 32'hA0, 1);
      add(1, 0, 1, 32'hA2, 0, 1, 1, 32'hA0, 2);
      add(1, 0, 1, 32'hA3, 0, 1, 1, 32'hA0, 3);
      add(1, 0, 1, 32'hA4, 0, 0, 1, 32'hA0, 4);
      add(1, 0, 0, 32'h00, 1, 0, 1, 32'hA0, 4);
      add(1, 0, 0, 32'h00, 1, 1, 1, 32'hA1, 3);
      add(1, 0, 0, 32'h00, 1, 1, 1, 32'hA2, 2);
      add(1, 0, 0, 32'h00, 1, 1, 1, 32'hA3, 1);
      add(1, 0, 0, 32'h00, 1, 1, 0, 32'hA0, 0);
      // DEPTH=2 PASS=1 flush collision
      add_rst(3);
      add(3, 0, 1, 32'h05, 0, 1, 0, 32'h00, 0);
      add(3, 0, 1, 32'h06, 0, 1, 1, 32'h05, 1);
      add(3, 1, 1, 32'h07, 1, 1, 1, 32'h05, 2);
      add(3, 0, 0, 32'h00, 1, 1, 0, 32'h05, 0);
      add(3, 0, 1, 32'h08, 0, 1, 0, 32'h05, 0);
      add(3, 0, 0, 32'h00, 0, 1, 1, 32'h08, 1);
      // DEPTH=2 PASS=1 full slide
      add_rst(3);
      add(3, 0, 1, 32'h01, 0, 1, 0, 32'h00, 0);
      add(3, 0, 1, 32'h02, 0, 1, 1, 32'h01, 1);
      add(3, 0, 1, 32'h03, 1, 1, 1, 32'h01, 2);
      add(3, 0, 1, 32'h04, 1, 1, 1, 32'h02, 2);
      add(3, 0, 0, 32'h00, 1, 1, 1, 32'h03, 2);
      add(3, 0, 0, 32'h00, 1, 1, 1, 32'h04, 1);
      add(3, 0, 0, 32'h00, 0, 1, 0, 32'h03, 0);
      // DEPTH=1 PASS=0 half throughput
      add_rst(4);
      add(4, 0, 1, 32'hB0, 1, 1, 0, 32'h00, 0);
      add(4, 0, 1, 32'hB1, 1, 0, 1, 32'hB0, 1);
      add(4, 0, 1, 32'hB1, 1, 1, 0, 32'hB0, 0);
      add(4, 0, 1, 32'hB2, 1, 0, 1, 32'hB1, 1);
      add(4, 0, 0, 32'h00, 1, 1, 0, 32'hB1, 0);

      sel = 0; reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0; in_data = '0;
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         sel       = tbl[i].inst;
         reset     = tbl[i].rst;
         flush     = tbl[i].fl;
         in_valid  = tbl[i].iv;
         in_data   = tbl[i].id;
         out_ready = tbl[i].ordy;
         #1;
         if (!tbl[i].rst) begin
            chk($sformatf("row%0d in_ready", i), {31'h0, c_ir}, {31'h0, tbl[i].e_ir});
            chk($sformatf("row%0d out_valid", i), {31'h0, c_ov}, {31'h0, tbl[i].e_ov});
            chk($sformatf("row%0d out_data", i), c_od, tbl[i].e_od);
            chk($sformatf("row%0d count", i), {29'h0, c_cnt}, 32'(tbl[i].e_cnt));
         end
         @(posedge clk); #1;
      end

      // DEPTH=3 wrap-around against a queue model
      sel = 2; reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      nxt = 8'hC0;
      for (int c = 0; c < 16; c++) begin
         in_valid  = (c < 10);
         in_data   = {24'h0, nxt};
         out_ready = pat[c];
         #1;
         exp_ir = (q.size() < 3) || out_ready;
         chk($sformatf("wrap%0d in_ready", c), {31'h0, c_ir}, {31'h0, exp_ir});
         chk($sformatf("wrap%0d out_valid", c), {31'h0, c_ov},
             {31'h0, q.size() != 0});
         chk($sformatf("wrap%0d count", c), {29'h0, c_cnt}, 32'(q.size()));
         if (q.size() != 0 && out_ready) begin
            chk($sformatf("wrap%0d out_data", c), c_od, {24'h0, q[0]});
            void'(q.pop_front());
         end
         if (in_valid && exp_ir) begin
            q.push_back(nxt);
            nxt = nxt + 8'h1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("wrap end out_valid", {31'h0, c_ov}, 32'h0);
      chk("wrap end count", {29'h0, c_cnt}, 32'h0);

      // mid-stream reset clears entries
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 32'hD0;
      @(posedge clk); #1;
      in_data = 32'hD1;
      @(posedge clk); #1;
      reset = 1'b1; in_data = 32'hD2;
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0;
      #1;
      chk("midrst out_valid", {31'h0, c_ov}, 32'h0);
      chk("midrst out_data", c_od, 32'h0);
      chk("midrst count", {29'h0, c_cnt}, 32'h0);
      chk("midrst in_ready", {31'h0, c_ir}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
